// File: rtl/wash_cycle_controller_pkg.sv
// wm_pkg: state codes shared by the wash cycle controller, its interface and the bench.
package wm_pkg;
    localparam int STATE_W = 4;
    typedef enum logic [STATE_W-1:0] {
        IDLE  = 4'd0,
        FILL  = 4'd1,
        WASH  = 4'd2,
        DRAIN = 4'd3,
        RINSE = 4'd4,
        SPIN  = 4'd5,
        DONE  = 4'd6,
        FAULT = 4'd7
    } state_t;
endpackage

// File: rtl/wash_cycle_controller_if.sv
// wash_cycle_controller_if: front-panel/sensor inputs and state/status outputs of the controller.
interface wash_cycle_controller_if #(parameter int PRICE = 2);
    import wm_pkg::*;
    logic                         sig_Coin;
    logic                         sig_Lid_Closed;
    logic                         sig_Cancel;
    logic                         sig_Out_Of_Balance;
    logic                         sig_Motor_Failure;
    logic [STATE_W-1:0]           state;
    logic [$clog2(PRICE+1)-1:0]   credit;
    logic                         paused;
    logic                         fault;
    modport master (
        output sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Out_Of_Balance, sig_Motor_Failure,
        input  state, credit, paused, fault
    );
    modport slave (
        input  sig_Coin, sig_Lid_Closed, sig_Cancel, sig_Out_Of_Balance, sig_Motor_Failure,
        output state, credit, paused, fault
    );
endinterface

// File: rtl/wash_cycle_controller_phase_timer.sv
// wm_phase_timer: loadable down-counter that holds at zero; zero flags the last cycle of a phase.
module wm_phase_timer #(
    parameter int TMR_W = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load,
    input  logic [TMR_W-1:0] load_val,
    input  logic             en,
    output logic             zero
);
    logic [TMR_W-1:0] r_cnt;
    assign zero = (r_cnt == '0);
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) r_cnt <= '0;
        else if (load) r_cnt <= load_val;
        else if (en && !zero) r_cnt <= r_cnt - 1'b1;
    end
endmodule

// File: rtl/wash_cycle_controller.sv
// wash_cycle_controller: coin-operated wash sequencer with lid pause, rinse passes,
// spin rebalance retries and a latched fault state.
module wash_cycle_controller
    import wm_pkg::*;
#(
    parameter int PRICE     = 2,
    parameter int T_FILL    = 8,
    parameter int T_WASH    = 16,
    parameter int T_DRAIN   = 8,
    parameter int T_RINSE   = 8,
    parameter int T_SPIN    = 12,
    parameter int N_RINSE   = 2,
    parameter int MAX_REBAL = 2,
    parameter int TMR_W     = 16
) (
    input  logic                   clock,
    input  logic                   reset_n,
    wash_cycle_controller_if.slave bus
);
    localparam int CW = $clog2(PRICE + 1);
    localparam int RW = $clog2(N_RINSE + 2);
    localparam int BW = $clog2(MAX_REBAL + 1);

    state_t           r_state, w_next;
    logic [CW-1:0]    r_credit, w_credit;
    logic [RW-1:0]    r_rinse, w_rinse;
    logic [BW-1:0]    r_rebal, w_rebal;
    logic             r_coin_q, r_flag, w_flag, r_paused, r_fault;
    logic             w_pause, w_load, w_zero, w_edge;
    logic [TMR_W-1:0] w_load_val;

    assign w_edge = bus.sig_Coin & ~r_coin_q;

    wm_phase_timer #(.TMR_W(TMR_W)) u_timer (
        .clock    (clock),
        .reset_n  (reset_n),
        .load     (w_load),
        .load_val (w_load_val),
        .en       (~w_pause),
        .zero     (w_zero)
    );

    always_comb begin
        w_next     = r_state;
        w_credit   = r_credit;
        w_rinse    = r_rinse;
        w_rebal    = r_rebal;
        w_flag     = r_flag;
        w_pause    = 1'b0;
        w_load     = 1'b0;
        w_load_val = '0;
        case (r_state)
            IDLE: begin
                if (bus.sig_Cancel) w_credit = '0;
                else if (r_credit == CW'(PRICE) && bus.sig_Lid_Closed) begin
                    w_next     = FILL;
                    w_credit   = '0;
                    w_load     = 1'b1;
                    w_load_val = TMR_W'(T_FILL - 1);
                end else if (w_edge && r_credit != CW'(PRICE)) w_credit = r_credit + 1'b1;
            end
            DONE:  if (!bus.sig_Lid_Closed) w_next = IDLE;
            FAULT: if (bus.sig_Cancel) w_next = IDLE;
            FILL, WASH, DRAIN, RINSE, SPIN: begin
                if (bus.sig_Motor_Failure && r_state inside {WASH, RINSE, SPIN}) w_next = FAULT;
                else if (bus.sig_Cancel && r_state != DRAIN) begin
                    w_next     = DRAIN;
                    w_flag     = 1'b1;
                    w_load     = 1'b1;
                    w_load_val = TMR_W'(T_DRAIN - 1);
                end else begin
                    // a cancel during DRAIN only marks the cycle; the drain itself runs to completion
                    w_flag = r_flag | bus.sig_Cancel;
                    if (!bus.sig_Lid_Closed) w_pause = 1'b1;
                    else if (r_state == SPIN && bus.sig_Out_Of_Balance) begin
                        w_rebal = r_rebal + 1'b1;
                        if (w_rebal == BW'(MAX_REBAL)) w_next = FAULT;
                        else begin
                            w_load     = 1'b1;
                            w_load_val = TMR_W'(T_SPIN - 1);
                        end
                    end else if (w_zero) begin
                        w_load = 1'b1;
                        case (r_state)
                            FILL: begin
                                w_next     = WASH;
                                w_load_val = TMR_W'(T_WASH - 1);
                            end
                            WASH, RINSE: begin
                                w_next     = DRAIN;
                                w_load_val = TMR_W'(T_DRAIN - 1);
                            end
                            SPIN: w_next = DONE;
                            default: begin
                                if (w_flag) w_next = DONE;
                                else if (r_rinse < RW'(N_RINSE)) begin
                                    w_next     = RINSE;
                                    w_rinse    = r_rinse + 1'b1;
                                    w_load_val = TMR_W'(T_RINSE - 1);
                                end else begin
                                    w_next     = SPIN;
                                    w_rebal    = '0;
                                    w_load_val = TMR_W'(T_SPIN - 1);
                                end
                            end
                        endcase
                    end
                end
            end
            default: w_next = IDLE;
        endcase
        if (w_next == IDLE) begin
            w_flag  = 1'b0;
            w_rinse = '0;
            w_rebal = '0;
        end
    end

    // paused reports that the previous cycle was frozen by an open lid
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state  <= IDLE;
            r_credit <= '0;
            r_rinse  <= '0;
            r_rebal  <= '0;
            r_flag   <= 1'b0;
            r_coin_q <= 1'b0;
            r_paused <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_next;
            r_credit <= w_credit;
            r_rinse  <= w_rinse;
            r_rebal  <= w_rebal;
            r_flag   <= w_flag;
            r_coin_q <= bus.sig_Coin;
            r_paused <= w_pause;
            r_fault  <= (w_next == FAULT);
        end
    end

    assign bus.state  = r_state;
    assign bus.credit = r_credit;
    assign bus.paused = r_paused;
    assign bus.fault  = r_fault;
endmodule

// File: tb/tb_wash_cycle_controller.sv
// tb_wash_cycle_controller: drives a 2-rinse and a 0-rinse controller from shared inputs and
// checks both against a remaining-cycles phase model every cycle plus literal checkpoints.
module tb_wash_cycle_controller;
    localparam int PRICE = 2, T_FILL = 8, T_WASH = 16, T_DRAIN = 8, T_RINSE = 8, T_SPIN = 12;
    localparam int MAX_REBAL = 2;

    logic clock = 1'b0, reset_n = 1'b0;
    logic coin = 1'b0, lid = 1'b1, cancel = 1'b0, oob = 1'b0, mf = 1'b0;
    int   n_tests = 0, n_fail = 0;
    bit   seen_spin0 = 1'b0;

    always #5 clock = ~clock;

    wash_cycle_controller_if #(.PRICE(PRICE)) if0 ();
    wash_cycle_controller_if #(.PRICE(PRICE)) if1 ();
    assign if0.sig_Coin = coin;
    assign if0.sig_Lid_Closed = lid;
    assign if0.sig_Cancel = cancel;
    assign if0.sig_Out_Of_Balance = oob;
    assign if0.sig_Motor_Failure = mf;
    assign if1.sig_Coin = coin;
    assign if1.sig_Lid_Closed = lid;
    assign if1.sig_Cancel = cancel;
    assign if1.sig_Out_Of_Balance = oob;
    assign if1.sig_Motor_Failure = mf;

    wash_cycle_controller #(.N_RINSE(2)) u0 (.clock(clock), .reset_n(reset_n), .bus(if0));
    wash_cycle_controller #(.N_RINSE(0)) u1 (.clock(clock), .reset_n(reset_n), .bus(if1));

    int d_state[2], d_credit[2], d_paused[2], d_fault[2];
    always_comb begin
        d_state[0] = int'(if0.state);   d_state[1] = int'(if1.state);
        d_credit[0] = int'(if0.credit); d_credit[1] = int'(if1.credit);
        d_paused[0] = int'(if0.paused); d_paused[1] = int'(if1.paused);
        d_fault[0] = int'(if0.fault);   d_fault[1] = int'(if1.fault);
    end

    // model: phase, cycles left in it (counting the current one), counters
    int m_state[2], m_left[2], m_credit[2], m_rinse[2], m_rebal[2];
    bit m_flag[2], m_paused[2], m_coin_prev;

    function automatic int nr(int k);
        return (k == 0) ? 2 : 0;
    endfunction

    function automatic int dur(int s);
        case (s)
            1: return T_FILL;
            2: return T_WASH;
            3: return T_DRAIN;
            4: return T_RINSE;
            5: return T_SPIN;
            default: return 0;
        endcase
    endfunction

    task automatic m_go(int k, int s);
        m_state[k] = s;
        m_left[k] = dur(s);
        if (s == 4) m_rinse[k]++;
        if (s == 5) m_rebal[k] = 0;
        if (s == 0) begin
            m_flag[k] = 0; m_rinse[k] = 0; m_rebal[k] = 0;
        end
    endtask

    task automatic m_step(int k);
        int s = m_state[k];
        bit edge_c = coin && !m_coin_prev;
        m_paused[k] = 0;
        if (s == 0) begin
            if (cancel) m_credit[k] = 0;
            else if (m_credit[k] == PRICE && lid) begin
                m_credit[k] = 0;
                m_go(k, 1);
            end else if (edge_c && m_credit[k] < PRICE) m_credit[k]++;
        end else if (s == 6) begin
            if (!lid) m_go(k, 0);
        end else if (s == 7) begin
            if (cancel) m_go(k, 0);
        end else if (s > 7) m_go(k, 0);
        else if (mf && (s == 2 || s == 4 || s == 5)) m_state[k] = 7;
        else if (cancel && s != 3) begin
            m_flag[k] = 1;
            m_go(k, 3);
        end else begin
            if (cancel) m_flag[k] = 1;
            if (!lid) m_paused[k] = 1;
            else if (s == 5 && oob) begin
                m_rebal[k]++;
                if (m_rebal[k] == MAX_REBAL) m_state[k] = 7;
                else m_left[k] = T_SPIN;
            end else if (m_left[k] > 1) m_left[k]--;
            else m_go(k, s == 1 ? 2 : s == 2 ? 3 : s == 4 ? 3 : s == 5 ? 6 :
                         m_flag[k] ? 6 : (m_rinse[k] < nr(k)) ? 4 : 5);
        end
    endtask

    always @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < 2; k++) begin
                m_state[k] = 0; m_left[k] = 0; m_credit[k] = 0; m_rinse[k] = 0;
                m_rebal[k] = 0; m_flag[k] = 0; m_paused[k] = 0;
            end
            m_coin_prev = 0;
        end else begin
            for (int k = 0; k < 2; k++) m_step(k);
            m_coin_prev = coin;
        end
    end

    task automatic check(string name, int act, int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    always @(negedge clock) begin
        if (reset_n) begin
            for (int k = 0; k < 2; k++) begin
                check($sformatf("model_state%0d", k), d_state[k], m_state[k]);
                check($sformatf("model_credit%0d", k), d_credit[k], m_credit[k]);
                check($sformatf("model_paused%0d", k), d_paused[k], int'(m_paused[k]));
                check($sformatf("model_fault%0d", k), d_fault[k], int'(m_state[k] == 7));
            end
            if (d_state[0] == 5) seen_spin0 = 1'b1;
        end
    end

    task automatic cyc(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic do_reset();
        @(negedge clock);
        reset_n = 1'b0; coin = 1'b0; lid = 1'b1; cancel = 1'b0; oob = 1'b0; mf = 1'b0;
        @(negedge clock);
        reset_n = 1'b1;
    endtask

    task automatic start();
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
    endtask

    task automatic both(string name, int s);
        check({name, "_u0"}, d_state[0], s);
        check({name, "_u1"}, d_state[1], s);
    endtask

    initial begin
        do_reset();
        for (int k = 0; k < 2; k++) begin
            check("rst_state", d_state[k], 0);
            check("rst_credit", d_credit[k], 0);
            check("rst_paused", d_paused[k], 0);
            check("rst_fault", d_fault[k], 0);
        end
        // full default cycle; 0-rinse build goes DRAIN->SPIN and finishes 32 cycles earlier
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
        check("t1_credit1", d_credit[0], 1);
        coin = 1'b1; cyc(1); coin = 1'b0;
        check("t1_credit2", d_credit[0], 2);
        cyc(1);
        both("t1_fill", 1);
        check("t1_credit_clr", d_credit[0], 0);
        cyc(32);
        check("t1_rinse_u0", d_state[0], 4);
        check("t1_spin_u1", d_state[1], 5);
        cyc(43);
        check("t1_spin_u0", d_state[0], 5);
        check("t1_done_u1", d_state[1], 6);
        cyc(1);
        check("t1_done_u0", d_state[0], 6);
        lid = 1'b0; cyc(1);
        both("t1_idle", 0);
        // coin level held, saturation, cancel, async reset with credit held
        coin = 1'b1; cyc(10); coin = 1'b0; cyc(1);
        check("t2_held", d_credit[0], 1);
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
        check("t2_credit2", d_credit[0], 2);
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
        check("t2_sat", d_credit[0], 2);
        both("t2_lid_open_idle", 0);
        cancel = 1'b1; cyc(1); cancel = 1'b0;
        check("t2_cancel", d_credit[0], 0);
        coin = 1'b1; cyc(1); coin = 1'b0; cyc(1);
        check("t2_credit_pre_rst", d_credit[1], 1);
        #2 reset_n = 1'b0;
        #1 check("t2_async_credit", d_credit[1], 0);
        lid = 1'b1;
        @(negedge clock) reset_n = 1'b1;
        // lid open 5 cycles mid-WASH
        do_reset(); start();
        cyc(13); lid = 1'b0; cyc(5);
        check("t3_paused", d_paused[0], 1);
        both("t3_frozen", 2);
        lid = 1'b1; cyc(10);
        both("t3_wash_end", 2);
        cyc(1);
        both("t3_drain", 3);
        check("t3_unpaused", d_paused[0], 0);
        // cancel in first rinse (u0) / in spin (u1)
        do_reset(); seen_spin0 = 1'b0; start();
        cyc(34); cancel = 1'b1; cyc(1); cancel = 1'b0;
        both("t4_drain", 3);
        cyc(7);
        both("t4_drain_end", 3);
        cyc(1);
        both("t4_done", 6);
        check("t4_no_spin_u0", int'(seen_spin0), 0);
        // imbalance: one event restarts SPIN, second one faults
        do_reset(); start();
        cyc(66); oob = 1'b1; cyc(1); oob = 1'b0;
        check("t5_spin", d_state[0], 5);
        cyc(11);
        check("t5_spin_restart", d_state[0], 5);
        cyc(1);
        check("t5_done", d_state[0], 6);
        lid = 1'b0; cyc(1); lid = 1'b1;
        start();
        cyc(66); oob = 1'b1; cyc(1); oob = 1'b0;
        cyc(3); oob = 1'b1; cyc(1); oob = 1'b0;
        check("t5_fault_state", d_state[0], 7);
        check("t5_fault_flag", d_fault[0], 1);
        lid = 1'b0; cyc(2);
        check("t5_fault_hold", d_state[0], 7);
        lid = 1'b1; cancel = 1'b1; cyc(1); cancel = 1'b0;
        check("t5_clear_state", d_state[0], 0);
        check("t5_clear_fault", d_fault[0], 0);
        // motor failure ignored in FILL, acts in WASH even with lid open
        do_reset(); start();
        cyc(2); mf = 1'b1; cyc(1); mf = 1'b0;
        both("t6_fill_mf", 1);
        cyc(7); lid = 1'b0; cyc(2);
        check("t6_paused", d_paused[1], 1);
        mf = 1'b1; cyc(1); mf = 1'b0;
        both("t6_fault", 7);
        check("t6_fault_flag", d_fault[1], 1);
        lid = 1'b1; cancel = 1'b1; cyc(1); cancel = 1'b0;
        both("t6_idle", 0);
        // async reset during SPIN
        start();
        cyc(32);
        check("t6_rinse_u0", d_state[0], 4);
        check("t6_spin_u1", d_state[1], 5);
        cyc(34);
        check("t6_spin_u0", d_state[0], 5);
        #2 reset_n = 1'b0;
        #1 both("t6_async_rst", 0);
        check("t6_async_credit", d_credit[0], 0);
        check("t6_async_fault", d_fault[0], 0);
        @(negedge clock) reset_n = 1'b1;
        cyc(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
